// File: rtl/exe_stage_pkg.sv
// Shared encodings for the execute stage: ALU commands, shift types,
// forwarding selects and the NZCV flag layout.
package exe_stage_pkg;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_MEM     = 2'b01,
        FWD_WB      = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                             input logic [31:0] reg_val,
                                             input logic [31:0] mem_val,
                                             input logic [31:0] wb_val);
        case (fwd_sel_e'(sel))
            FWD_MEM: fwd_mux = mem_val;
            FWD_WB:  fwd_mux = wb_val;
            default: fwd_mux = reg_val;
        endcase
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX input bundle and EXE/MEM output bundle of the execute stage.
// master = upstream pipeline side, slave = exe_stage.
interface exe_stage_if;

    logic        wb_en;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        B;
    logic        S;
    logic [3:0]  exe_cmd;
    logic [31:0] PC;
    logic [31:0] val_Rn;
    logic [31:0] val_Rm;
    logic [11:0] shift_operand;
    logic        imm;
    logic [3:0]  dest;
    logic [23:0] signed_imm_24;

    logic        wb_en_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest_o;

    modport master (
        output wb_en, mem_read_en, mem_write_en, B, S, exe_cmd, PC, val_Rn,
               val_Rm, shift_operand, imm, dest, signed_imm_24,
        input  wb_en_o, mem_read_en_o, mem_write_en_o, alu_res, st_val, dest_o
    );

    modport slave (
        input  wb_en, mem_read_en, mem_write_en, B, S, exe_cmd, PC, val_Rn,
               val_Rm, shift_operand, imm, dest, signed_imm_24,
        output wb_en_o, mem_read_en_o, mem_write_en_o, alu_res, st_val, dest_o
    );

endinterface

// File: rtl/exe_stage_val2_generator.sv
// Second ALU operand: memory offset, rotated 8-bit immediate, or the
// shifted register operand.
module val2_generator
    import exe_stage_pkg::*;
(
    input  logic        mem_en,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [31:0] rm_val,
    output logic [31:0] val2
);

    logic [31:0] imm8;
    logic [4:0]  imm_rot;
    logic [4:0]  sh_amt;
    logic [63:0] imm_dbl;
    logic [63:0] rm_dbl;
    logic [31:0] imm_val;
    logic [31:0] reg_val;

    assign imm8    = {24'b0, shift_operand[7:0]};
    assign imm_rot = {shift_operand[11:8], 1'b0};
    assign sh_amt  = shift_operand[11:7];
    // Rotations done as a right shift of the operand concatenated with itself.
    assign imm_dbl = {imm8, imm8} >> imm_rot;
    assign rm_dbl  = {rm_val, rm_val} >> sh_amt;
    assign imm_val = imm_dbl[31:0];

    always_comb begin
        reg_val = rm_val;
        case (shift_e'(shift_operand[6:5]))
            SH_LSL:  reg_val = rm_val << sh_amt;
            SH_LSR:  reg_val = rm_val >> sh_amt;
            SH_ASR:  reg_val = $signed(rm_val) >>> sh_amt;
            SH_ROR:  reg_val = rm_dbl[31:0];
            default: reg_val = rm_val;
        endcase
    end

    always_comb begin
        if (mem_en)
            val2 = {20'b0, shift_operand};
        else if (imm)
            val2 = imm_val;
        else
            val2 = reg_val;
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, NZCV status register, branch
// target and EXE/MEM pipeline register. EXE_FORWARDING_EN enables forwarding.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    exe_stage_if.slave        bus,
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [31:0]       mem_fwd_val,
    input  logic [31:0]       wb_fwd_val,
    output logic              branch_taken,
    output logic [31:0]       branch_addr,
    output logic [3:0]        status_bits
);

    logic [31:0] op1;
    logic [31:0] src2;
    logic [31:0] val2;

`ifdef EXE_FORWARDING_EN
    assign op1  = fwd_mux(sel_src1, bus.val_Rn, mem_fwd_val, wb_fwd_val);
    assign src2 = fwd_mux(sel_src2, bus.val_Rm, mem_fwd_val, wb_fwd_val);
`else
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, mem_fwd_val, wb_fwd_val};
    assign op1  = bus.val_Rn;
    assign src2 = bus.val_Rm;
`endif

    val2_generator u_val2 (
        .mem_en        (bus.mem_read_en | bus.mem_write_en),
        .imm           (bus.imm),
        .shift_operand (bus.shift_operand),
        .rm_val        (src2),
        .val2          (val2)
    );

    nzcv_t       status_q;
    nzcv_t       flags_next;
    logic [31:0] alu_res_next;
    logic        cmd_valid;
    logic        is_arith;
    logic [31:0] add_b;
    logic        add_cin;
    logic [32:0] sum;

    // Subtraction is op1 + ~val2 + carry-in, so C comes out as no-borrow.
    always_comb begin
        alu_res_next = '0;
        flags_next   = status_q;
        cmd_valid    = 1'b1;
        is_arith     = 1'b0;
        add_b        = '0;
        add_cin      = 1'b0;
        sum          = '0;
        case (exe_cmd_e'(bus.exe_cmd))
            CMD_MOV: alu_res_next = val2;
            CMD_MVN: alu_res_next = ~val2;
            CMD_ADD: begin is_arith = 1'b1; add_b = val2;  add_cin = 1'b0;       end
            CMD_ADC: begin is_arith = 1'b1; add_b = val2;  add_cin = status_q.c; end
            CMD_SUB: begin is_arith = 1'b1; add_b = ~val2; add_cin = 1'b1;       end
            CMD_SBC: begin is_arith = 1'b1; add_b = ~val2; add_cin = status_q.c; end
            CMD_AND: alu_res_next = op1 & val2;
            CMD_ORR: alu_res_next = op1 | val2;
            CMD_EOR: alu_res_next = op1 ^ val2;
            default: cmd_valid = 1'b0;
        endcase
        if (is_arith) begin
            sum          = {1'b0, op1} + {1'b0, add_b} + {32'b0, add_cin};
            alu_res_next = sum[31:0];
            flags_next.c = sum[32];
            flags_next.v = (op1[31] == add_b[31]) && (sum[31] != op1[31]);
        end
        if (cmd_valid) begin
            flags_next.n = alu_res_next[31];
            flags_next.z = (alu_res_next == 32'b0);
        end
    end

    // freeze=1 is a stall: every register holds, an S=1 update in that cycle is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            status_q <= '0;
        else if (!freeze && bus.S)
            status_q <= flags_next;
    end

    logic        wb_en_q;
    logic        mem_read_en_q;
    logic        mem_write_en_q;
    logic [31:0] alu_res_q;
    logic [31:0] st_val_q;
    logic [3:0]  dest_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q        <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            alu_res_q      <= '0;
            st_val_q       <= '0;
            dest_q         <= '0;
        end else if (!freeze) begin
            wb_en_q        <= bus.wb_en;
            mem_read_en_q  <= bus.mem_read_en;
            mem_write_en_q <= bus.mem_write_en;
            alu_res_q      <= alu_res_next;
            st_val_q       <= src2;
            dest_q         <= bus.dest;
        end
    end

    assign bus.wb_en_o        = wb_en_q;
    assign bus.mem_read_en_o  = mem_read_en_q;
    assign bus.mem_write_en_o = mem_write_en_q;
    assign bus.alu_res        = alu_res_q;
    assign bus.st_val         = st_val_q;
    assign bus.dest_o         = dest_q;
    assign status_bits        = status_q;

    assign branch_taken = bus.B;
    assign branch_addr  = bus.PC + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage: ALU, flags, shifter, branch target,
// freeze/reset behaviour and the optional forwarding path.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [31:0] mem_fwd_val;
    logic [31:0] wb_fwd_val;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status_bits;

    int checks = 0;
    int errors = 0;

    exe_stage_if bus ();

    exe_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .bus          (bus),
        .sel_src1     (sel_src1),
        .sel_src2     (sel_src2),
        .mem_fwd_val  (mem_fwd_val),
        .wb_fwd_val   (wb_fwd_val),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .status_bits  (status_bits)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wb_en = 1'b0; bus.mem_read_en = 1'b0; bus.mem_write_en = 1'b0;
        bus.B = 1'b0; bus.S = 1'b0; bus.exe_cmd = 4'b0000; bus.PC = '0;
        bus.val_Rn = '0; bus.val_Rm = '0; bus.shift_operand = '0; bus.imm = 1'b0;
        bus.dest = '0; bus.signed_imm_24 = '0;
        sel_src1 = 2'b00; sel_src2 = 2'b00; mem_fwd_val = '0; wb_fwd_val = '0;
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic s, input logic [31:0] rn,
                          input logic im, input logic [11:0] so);
        bus.exe_cmd = cmd; bus.S = s; bus.val_Rn = rn; bus.imm = im; bus.shift_operand = so;
    endtask

    // checker
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu"},   bus.alu_res, 32'h0);
        chk({tag, "_st"},    bus.st_val, 32'h0);
        chk({tag, "_dest"},  {28'b0, bus.dest_o}, 32'h0);
        chk({tag, "_wb"},    {31'b0, bus.wb_en_o}, 32'h0);
        chk({tag, "_mrd"},   {31'b0, bus.mem_read_en_o}, 32'h0);
        chk({tag, "_mwr"},   {31'b0, bus.mem_write_en_o}, 32'h0);
        chk({tag, "_nzcv"},  {28'b0, status_bits}, 32'h0);
    endtask

    initial begin
        logic [31:0] exp_fwd_alu;
        logic [31:0] exp_fwd_st;
        rst = 1'b1;
        freeze = 1'b0;
        clear_inputs();
        #1 rst = 1'b0;
        #1;
        chk_all_zero("reset");

        // ADD overflow into the sign bit; captured on the first edge after release
        set_op(CMD_ADD, 1'b1, 32'h7FFF_FFFF, 1'b1, 12'h001);
        bus.wb_en = 1'b1; bus.dest = 4'd3; bus.val_Rm = 32'hDEAD_0000;
        #1 rst = 1'b1;
        tick();
        chk("add_ovf_res",  bus.alu_res, 32'h8000_0000);
        chk("add_ovf_nzcv", {28'b0, status_bits}, 32'h9);
        chk("add_ovf_wb",   {31'b0, bus.wb_en_o}, 32'h1);
        chk("add_ovf_dest", {28'b0, bus.dest_o}, 32'h3);
        chk("add_ovf_st",   bus.st_val, 32'hDEAD_0000);

        // rotated immediate, flags untouched with S=0
        clear_inputs();
        set_op(CMD_MOV, 1'b0, 32'h0, 1'b1, 12'h4FF);
        tick();
        chk("mov_rot_res",  bus.alu_res, 32'hFF00_0000);
        chk("mov_rot_nzcv", {28'b0, status_bits}, 32'h9);
        chk("mov_rot_wb",   {31'b0, bus.wb_en_o}, 32'h0);

        // branch target is combinational
        bus.B = 1'b1; bus.PC = 32'h100; bus.signed_imm_24 = 24'hFF_FFFE;
        #1;
        chk("br_back_taken", {31'b0, branch_taken}, 32'h1);
        chk("br_back_addr",  branch_addr, 32'h0000_00F8);
        bus.B = 1'b0; bus.PC = 32'h1000; bus.signed_imm_24 = 24'h00_0010;
        #1;
        chk("br_fwd_taken", {31'b0, branch_taken}, 32'h0);
        chk("br_fwd_addr",  branch_addr, 32'h0000_1040);

        // SUB equal operands, then ADC consuming C=1
        clear_inputs();
        set_op(CMD_SUB, 1'b1, 32'd5, 1'b1, 12'h005);
        tick();
        chk("sub_eq_res",  bus.alu_res, 32'h0);
        chk("sub_eq_nzcv", {28'b0, status_bits}, 32'h6);
        set_op(CMD_ADC, 1'b1, 32'd1, 1'b1, 12'h001);
        tick();
        chk("adc_res",  bus.alu_res, 32'd3);
        chk("adc_nzcv", {28'b0, status_bits}, 32'h0);

        // SBC with C=0: 10 - 3 - 1
        set_op(CMD_SBC, 1'b1, 32'd10, 1'b1, 12'h003);
        tick();
        chk("sbc_res",  bus.alu_res, 32'd6);
        chk("sbc_nzcv", {28'b0, status_bits}, 32'h2);

        // logical op keeps C and V
        set_op(CMD_AND, 1'b1, 32'h0F, 1'b1, 12'h0F0);
        tick();
        chk("and_res",  bus.alu_res, 32'h0);
        chk("and_nzcv", {28'b0, status_bits}, 32'h6);

        // SUB with borrow
        set_op(CMD_SUB, 1'b1, 32'd3, 1'b1, 12'h005);
        tick();
        chk("sub_brw_res",  bus.alu_res, 32'hFFFF_FFFE);
        chk("sub_brw_nzcv", {28'b0, status_bits}, 32'h8);

        // unsigned carry-out of ADD
        set_op(CMD_ADD, 1'b1, 32'hFFFF_FFFF, 1'b1, 12'h001);
        tick();
        chk("add_cout_res",  bus.alu_res, 32'h0);
        chk("add_cout_nzcv", {28'b0, status_bits}, 32'h6);

        // undefined command: result 0, flags unchanged even with S=1
        set_op(CMD_EOR, 1'b1, 32'hF0F0_F0F0, 1'b1, 12'h0FF);
        tick();
        chk("eor_res",  bus.alu_res, 32'hF0F0_F00F);
        chk("eor_nzcv", {28'b0, status_bits}, 32'hA);
        set_op(4'b0000, 1'b1, 32'h1234, 1'b1, 12'h001);
        tick();
        chk("nop_res",  bus.alu_res, 32'h0);
        chk("nop_nzcv", {28'b0, status_bits}, 32'hA);
        set_op(CMD_ORR, 1'b0, 32'h0000_1200, 1'b1, 12'h034);
        tick();
        chk("orr_res", bus.alu_res, 32'h0000_1234);
        set_op(CMD_MVN, 1'b0, 32'h0, 1'b1, 12'h000);
        tick();
        chk("mvn_res", bus.alu_res, 32'hFFFF_FFFF);

        // register shifter on val_Rm = 0x80000001
        bus.val_Rm = 32'h8000_0001;
        set_op(CMD_MOV, 1'b0, 32'h0, 1'b0, 12'h200);
        tick();
        chk("lsl4",  bus.alu_res, 32'h0000_0010);
        bus.shift_operand = 12'h0C0;
        tick();
        chk("asr1",  bus.alu_res, 32'hC000_0000);
        bus.shift_operand = 12'h260;
        tick();
        chk("ror4",  bus.alu_res, 32'h1800_0000);
        bus.shift_operand = 12'hFA0;
        tick();
        chk("lsr31", bus.alu_res, 32'h0000_0001);
        bus.shift_operand = 12'h020;
        tick();
        chk("lsr0",  bus.alu_res, 32'h8000_0001);

        // memory access: zero-extended offset wins over imm
        clear_inputs();
        set_op(CMD_ADD, 1'b0, 32'h1000, 1'b1, 12'hABC);
        bus.mem_read_en = 1'b1;
        tick();
        chk("mem_off_res", bus.alu_res, 32'h0000_1ABC);
        chk("mem_off_rd",  {31'b0, bus.mem_read_en_o}, 32'h1);

        // freeze: load a known instruction, then stall with changing inputs
        clear_inputs();
        set_op(CMD_ADD, 1'b1, 32'h20, 1'b1, 12'h005);
        bus.wb_en = 1'b1; bus.mem_write_en = 1'b1; bus.dest = 4'd7; bus.val_Rm = 32'h55;
        tick();
        chk("frz_pre_res",  bus.alu_res, 32'h25);
        chk("frz_pre_nzcv", {28'b0, status_bits}, 32'h0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(CMD_SUB, 1'b1, 32'h0, 1'b1, 12'h001);
            bus.wb_en = 1'b0; bus.mem_write_en = 1'b0;
            bus.dest = 4'(i); bus.val_Rm = 32'(i);
            tick();
            chk("frz_res",  bus.alu_res, 32'h25);
            chk("frz_nzcv", {28'b0, status_bits}, 32'h0);
            chk("frz_dest", {28'b0, bus.dest_o}, 32'h7);
            chk("frz_wb",   {31'b0, bus.wb_en_o}, 32'h1);
            chk("frz_mwr",  {31'b0, bus.mem_write_en_o}, 32'h1);
            chk("frz_st",   bus.st_val, 32'h55);
        end
        bus.B = 1'b1; bus.PC = 32'h0; bus.signed_imm_24 = 24'h00_0001;
        #1;
        chk("frz_br_taken", {31'b0, branch_taken}, 32'h1);
        chk("frz_br_addr",  branch_addr, 32'h4);

        // asynchronous reset in the middle of the stall
        rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        freeze = 1'b0;
        clear_inputs();
        set_op(CMD_ADD, 1'b0, 32'h30, 1'b1, 12'h001);
        tick();
        chk("post_rst_res", bus.alu_res, 32'h31);

        // forwarding selects
        clear_inputs();
        set_op(CMD_ADD, 1'b0, 32'h100, 1'b1, 12'h002);
        sel_src1 = 2'b01; mem_fwd_val = 32'h10;
        sel_src2 = 2'b10; wb_fwd_val = 32'hCAFE; bus.val_Rm = 32'hBEEF;
`ifdef EXE_FORWARDING_EN
        exp_fwd_alu = 32'h12;
        exp_fwd_st  = 32'hCAFE;
`else
        exp_fwd_alu = 32'h102;
        exp_fwd_st  = 32'hBEEF;
`endif
        tick();
        chk("fwd_res", bus.alu_res, exp_fwd_alu);
        chk("fwd_st",  bus.st_val, exp_fwd_st);
        sel_src1 = 2'b11; sel_src2 = 2'b11;
        tick();
        chk("fwd_reg_res", bus.alu_res, 32'h102);
        chk("fwd_reg_st",  bus.st_val, 32'hBEEF);

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
